shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that shares the single combinational 64-bit shifter (`Deslocamento`) between two requesters. It arbitrates between them round-robin and drives the shifter's `Shift`/`Entrada`/`N` inputs pass by pass. It implements the full RV64 shift set: SLL, SRL and SRA in one pass, and SLLW, SRLW and SRAW in three passes. Results return on a valid/ready handshake. The block sits between the execute-stage requesters and the shifter instance.

## Interface
Parameters: none; width fixed at 64 to match the shifter.

- `clk` in 1: the only clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation is accepted this cycle.
- `req0_op` in 3: 000 SLL, 001 SRL, 010 SRA, 100 SLLW, 101 SRLW, 110 SRAW. Codes 011 and 111 are illegal.
- `req0_data` in 64: operand.
- `req0_amt` in 6: shift amount.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_data`, `req1_amt`: same as requester 0, for requester 1.
- `resp_valid` out 1: a result is available.
- `resp_ready` in 1: the consumer takes the result.
- `resp_id` out 1: index of the requester that owns the result.
- `resp_data` out 64: result.
- `resp_err` out 1: the operation was illegal.
- `sh_shift` out 2: to shifter `Shift`. 00 = left logical, 01 = right logical, 10 = right arithmetic. Never driven to 11.
- `sh_entrada` out 64: to shifter `Entrada`.
- `sh_n` out 6: to shifter `N`.
- `sh_saida` in 64: from shifter `Saida`. The shifter is combinational.

## Operation
States: IDLE, PASS1, PASS2, PASS3, RESP.

IDLE
- The grant goes to the only valid requester. If both are valid, the grant goes to the requester that was not granted last.
- After reset, the last-granted pointer is 1, so requester 0 wins the first tie.
- `reqN_ready` is 1 only in IDLE, only for the granted requester, and only while its `reqN_valid` is 1. The other `ready` is 0.
- On accept, the block latches op, amt and id and loads `work` (64-bit register) with the operand.
  - Legal op: go to PASS1.
  - Illegal op: go directly to RESP with `resp_data` = 0 and `resp_err` = 1.

PASSk
- The shifter is driven from `work` and the per-pass code/amount listed below.
- `work` <= `sh_saida` at the end of the cycle.
- 64-bit ops take one pass:
  - PASS1: code from op (000 → 00, 001 → 01, 010 → 10), n = amt[5:0].
  - Then go to RESP.
- W ops take three passes:
  - PASS1: code 00, n = 32. Moves the low word to the upper half.
  - PASS2: code from op (100 → 00, 101 → 01, 110 → 10), n = {1'b0, amt[4:0]}. amt[5] is ignored.
  - PASS3: code 10, n = 32. Sign-extends the upper word into the result.
  - Then go to RESP.

RESP
- `resp_valid` = 1; `resp_data` = `work`; `resp_id` and `resp_err` come from the latched values.
- Outputs hold stable while `resp_ready` = 0.
- When `resp_valid` and `resp_ready` are both 1, go to IDLE next cycle. There is no accept in the same cycle.

Outside the PASS states, the shifter is driven with `sh_shift` = 00, `sh_n` = 0 and `sh_entrada` = `work`.

## Timing
Let T be the accept cycle.
- `resp_valid` rises at T+2 for 64-bit ops, T+4 for W ops, and T+1 for illegal ops.
- The earliest next accept is the cycle after the response handshake. Minimum 64-bit throughput is therefore one operation per 3 cycles.
- Shift amount 0 still uses its passes. The result equals the operand for 64-bit ops, and the sign-extended low word for W ops.

Reset values, applied in the cycle after `reset` is sampled high:
- State IDLE.
- `resp_valid`, `resp_err`, `resp_id` = 0; `resp_data` = 0 (`work` cleared).
- Both `ready` = 0 while `reset` is high.
- Last-granted pointer = 1.

Reset in any state, including mid-pass or RESP, discards the transaction with no response.

A requester that drops `valid` before it gets `ready` is not accepted. No operand from it is latched.

## Test plan
- req0 SLL, data 4, amt 2 → `resp_data` = 16, `resp_id` 0, `resp_valid` at T+2. SRL of 0xFFFFFFFFFFFFFFFC by 1 → 0x7FFFFFFFFFFFFFFE. SRA of 0xFFFFFFFFFFFFFF00 by 8 → 0xFFFFFFFFFFFFFFFF. Each result appears at T+2.
- W ops on data 0x0000000080000000 with amt 4:
  - SRLW → 0x0000000008000000.
  - SRAW → 0xFFFFFFFFF8000000.
  - Each result appears at T+4.
- SLLW on data 0x0000000140000000 with amt 33 (amt[5] ignored) → 0xFFFFFFFF80000000. The bench also checks that the `sh_shift`/`sh_n` sequence is 00/32, 00/1, 10/32.
- Both requesters valid continuously with `resp_ready` = 1 → grants alternate 0, 1, 0, 1. The first grant goes to 0. The requester not granted never sees `ready`.
- Back-pressure: `resp_ready` held at 0 for 5 cycles in RESP → `resp_*` stays stable and both `ready` stay 0. The handshake completes when `resp_ready` goes to 1.
- Reset and illegal op:
  - `reset` pulsed in PASS2 of an SRAW → IDLE next cycle, `resp_valid` stays 0, and the next tie is granted to requester 0.
  - op 011 → `resp_err` = 1, `resp_data` = 0, `resp_valid` at T+1.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: shares one combinational 64-bit shifter between two requesters.
// Arbitrates round-robin, sequences the shifter pass by pass (one pass for
// SLL/SRL/SRA, three passes for SLLW/SRLW/SRAW) and returns results on a
// valid/ready handshake.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   reqN_valid/ready/op/data/amt   requester N operation (N = 0, 1)
//   resp_valid/ready/id/data/err   result channel
//   sh_shift/sh_entrada/sh_n       drive the external shifter
//   sh_saida                       shifter result (combinational)
module shift_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [63:0] req0_data,
    input  logic [5:0]  req0_amt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [63:0] req1_data,
    input  logic [5:0]  req1_amt,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic [1:0]  sh_shift,
    output logic [63:0] sh_entrada,
    output logic [5:0]  sh_n,
    input  logic [63:0] sh_saida
);

    typedef enum logic [2:0] {StIdle, StPass1, StPass2, StPass3, StResp} state_e;

    state_e      state_q;
    logic [2:0]  op_q;
    logic [5:0]  amt_q;
    logic        id_q;
    logic        err_q;
    logic        last_q;
    logic [63:0] work_q;

    logic        grant;
    logic        accept;
    logic [2:0]  sel_op;
    logic [63:0] sel_data;
    logic [5:0]  sel_amt;

    // Arbitration: a lone requester wins; on a tie, the one not granted last.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end
        req0_ready = (state_q == StIdle) && !reset && req0_valid && !grant;
        req1_ready = (state_q == StIdle) && !reset && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        sel_op     = grant ? req1_op   : req0_op;
        sel_data   = grant ? req1_data : req0_data;
        sel_amt    = grant ? req1_amt  : req0_amt;
    end

    // Shifter drive per pass. W ops: park the low word high (<<32), shift it
    // there, then arithmetic >>32 to bring it down sign-extended.
    always_comb begin
        sh_shift   = 2'b00;
        sh_n       = 6'd0;
        sh_entrada = work_q;
        unique case (state_q)
            StPass1: begin
                if (op_q[2]) begin
                    sh_shift = 2'b00;
                    sh_n     = 6'd32;
                end else begin
                    sh_shift = op_q[1:0];
                    sh_n     = amt_q;
                end
            end
            StPass2: begin
                sh_shift = op_q[1:0];
                sh_n     = {1'b0, amt_q[4:0]};
            end
            StPass3: begin
                sh_shift = 2'b10;
                sh_n     = 6'd32;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 3'd0;
            amt_q   <= 6'd0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
            work_q  <= 64'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        id_q   <= grant;
                        last_q <= grant;
                        op_q   <= sel_op;
                        amt_q  <= sel_amt;
                        // Codes 011 and 111 are illegal.
                        if (sel_op[1:0] == 2'b11) begin
                            work_q  <= 64'd0;
                            err_q   <= 1'b1;
                            state_q <= StResp;
                        end else begin
                            work_q  <= sel_data;
                            err_q   <= 1'b0;
                            state_q <= StPass1;
                        end
                    end
                end
                StPass1: begin
                    work_q  <= sh_saida;
                    state_q <= op_q[2] ? StPass2 : StResp;
                end
                StPass2: begin
                    work_q  <= sh_saida;
                    state_q <= StPass3;
                end
                StPass3: begin
                    work_q  <= sh_saida;
                    state_q <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_id    = id_q;
    assign resp_err   = err_q;
    assign resp_data  = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with a behavioural shifter.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [63:0] req0_data, req1_data;
    logic [5:0]  req0_amt, req1_amt;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [63:0] resp_data;
    logic [1:0]  sh_shift;
    logic [63:0] sh_entrada, sh_saida;
    logic [5:0]  sh_n;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] seq_shift [0:3];
    logic [5:0] seq_n     [0:3];

    always #5 clk = ~clk;

    // Behavioural model of the external combinational shifter.
    always_comb begin
        case (sh_shift)
            2'b00:   sh_saida = sh_entrada << sh_n;
            2'b01:   sh_saida = sh_entrada >> sh_n;
            2'b10:   sh_saida = $unsigned($signed(sh_entrada) >>> sh_n);
            default: sh_saida = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    end

    shift_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .sh_shift   (sh_shift),
        .sh_entrada (sh_entrada),
        .sh_n       (sh_n),
        .sh_saida   (sh_saida)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issue one op from requester id and check result, id, error and latency.
    task automatic do_op(input bit id, input logic [2:0] op, input logic [63:0] data,
                         input logic [5:0] amt, input logic [63:0] exp, input bit exp_err,
                         input int exp_lat);
        int w;
        int lat;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_data = data; req1_amt = amt;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_data = data; req0_amt = amt;
        end
        #1;
        w = 0;
        while (!(id ? req1_ready : req0_ready) && w < 8) begin
            tick();
            w++;
        end
        check_eq("accept", 64'(id ? req1_ready : req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            if (lat <= 3) begin
                seq_shift[lat] = sh_shift;
                seq_n[lat]     = sh_n;
            end
            tick();
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("resp_data", resp_data, exp);
        check_eq("resp_err", 64'(resp_err), 64'(exp_err));
        check_eq("resp_id", 64'(resp_id), 64'(id));
        tick();
    endtask

    initial begin
        logic [63:0] hold_data;
        logic        hold_id;
        int          w;
        bit          exp_g;

        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'd0; req1_op = 3'd0;
        req0_data = 64'd0; req1_data = 64'd0;
        req0_amt = 6'd0; req1_amt = 6'd0;
        resp_ready = 1'b1;

        // Reset state, with both requesters valid.
        tick();
        tick();
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_resp_err", 64'(resp_err), 64'd0);
        check_eq("rst_resp_id", 64'(resp_id), 64'd0);
        check_eq("rst_resp_data", resp_data, 64'd0);
        check_eq("rst_ready0", 64'(req0_ready), 64'd0);
        check_eq("rst_ready1", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        tick();

        // 64-bit ops.
        do_op(1'b0, 3'b000, 64'd4, 6'd2, 64'd16, 1'b0, 2);
        do_op(1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 6'd1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 2);
        do_op(1'b0, 3'b010, 64'hFFFF_FFFF_FFFF_FF00, 6'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2);
        do_op(1'b1, 3'b000, 64'h1234_5678_9ABC_DEF0, 6'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 2);
        do_op(1'b0, 3'b001, 64'h8000_0000_0000_0000, 6'd63, 64'd1, 1'b0, 2);

        // W ops.
        do_op(1'b0, 3'b101, 64'h0000_0000_8000_0000, 6'd4, 64'h0000_0000_0800_0000, 1'b0, 4);
        do_op(1'b1, 3'b110, 64'h0000_0000_8000_0000, 6'd4, 64'hFFFF_FFFF_F800_0000, 1'b0, 4);
        do_op(1'b0, 3'b110, 64'hAAAA_AAAA_8000_0001, 6'd0, 64'hFFFF_FFFF_8000_0001, 1'b0, 4);
        do_op(1'b1, 3'b100, 64'h0000_0001_4000_0000, 6'd33, 64'hFFFF_FFFF_8000_0000, 1'b0, 4);
        check_eq("sllw_p1_shift", 64'(seq_shift[1]), 64'd0);
        check_eq("sllw_p1_n", 64'(seq_n[1]), 64'd32);
        check_eq("sllw_p2_shift", 64'(seq_shift[2]), 64'd0);
        check_eq("sllw_p2_n", 64'(seq_n[2]), 64'd1);
        check_eq("sllw_p3_shift", 64'(seq_shift[3]), 64'd2);
        check_eq("sllw_p3_n", 64'(seq_n[3]), 64'd32);

        // Illegal op.
        do_op(1'b0, 3'b011, 64'hFFFF_0000_FFFF_0000, 6'd3, 64'd0, 1'b1, 1);
        do_op(1'b1, 3'b111, 64'h1, 6'd3, 64'd0, 1'b1, 1);

        // Round-robin under continuous contention; first tie goes to 0 after reset.
        do_reset();
        req0_op = 3'b000; req0_data = 64'd1; req0_amt = 6'd1;
        req1_op = 3'b000; req1_data = 64'd1; req1_amt = 6'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        exp_g = 1'b0;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            while (!req0_ready && !req1_ready && w < 8) begin
                tick();
                w++;
            end
            check_eq("rr_ready0", 64'(req0_ready), 64'(!exp_g));
            check_eq("rr_ready1", 64'(req1_ready), 64'(exp_g));
            tick();
            w = 0;
            while (!resp_valid && w < 8) begin
                check_eq("rr_busy_ready", 64'({req0_ready, req1_ready}), 64'd0);
                tick();
                w++;
            end
            check_eq("rr_resp_id", 64'(resp_id), 64'(exp_g));
            check_eq("rr_resp_data", resp_data, exp_g ? 64'd4 : 64'd2);
            tick();
            exp_g = ~exp_g;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();

        // Back-pressure: hold RESP for 5 cycles with requester 1 waiting.
        resp_ready = 1'b0;
        req0_op = 3'b000; req0_data = 64'd3; req0_amt = 6'd4;
        req0_valid = 1'b1;
        #1;
        check_eq("bp_accept", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        tick();
        check_eq("bp_resp_valid", 64'(resp_valid), 64'd1);
        hold_data = resp_data;
        hold_id   = resp_id;
        check_eq("bp_resp_data", hold_data, 64'd48);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("bp_hold_valid", 64'(resp_valid), 64'd1);
            check_eq("bp_hold_data", resp_data, hold_data);
            check_eq("bp_hold_id", 64'(resp_id), 64'(hold_id));
            check_eq("bp_hold_ready", 64'({req0_ready, req1_ready}), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        check_eq("bp_done_valid", 64'(resp_valid), 64'd0);
        req1_valid = 1'b0;
        tick();
        // Requester 1 may have been accepted at that IDLE; drain its response.
        w = 0;
        while ((dut.state_q != 0) && w < 8) begin
            tick();
            w++;
        end

        // Reset during PASS2 of an SRAW discards the transaction.
        req1_op = 3'b110; req1_data = 64'h0000_0000_8000_0000; req1_amt = 6'd4;
        req1_valid = 1'b1;
        #1;
        check_eq("rst_mid_accept", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_mid_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_mid_data", resp_data, 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst_mid_no_resp", 64'(resp_valid), 64'd0);
        end
        req0_op = 3'b000; req0_data = 64'd5; req0_amt = 6'd0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_eq("rst_tie_ready0", 64'(req0_ready), 64'd1);
        check_eq("rst_tie_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check_eq("rst_tie_resp_valid", 64'(resp_valid), 64'd1);
        check_eq("rst_tie_resp_data", resp_data, 64'd5);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
